fifo_rd_packer: RTL

FIFO_RD_PACKER -- requirements
Module: fifo_rd_packer

---
 rtl/fifo_rd_packer.sv | 89 ++++++++
 1 files changed

// File: rtl/fifo_rd_packer.sv
// Pops bytes from a FIFO read port and packs LANES of them, little-endian, into one
// output word with a valid/ready handshake; a flush emits a partially filled word.
module fifo_rd_packer #(
  parameter int DATAWIDTH = 8,
  parameter int LANES     = 4
) (
  input  logic                           rd_clk,
  input  logic                           rd_rst,
  input  logic                           fifo_empty,
  output logic                           rd_en,
  input  logic [DATAWIDTH-1:0]           rd_data,
  input  logic                           flush,
  output logic [DATAWIDTH*LANES-1:0]     out_word,
  output logic [LANES-1:0]               out_keep,
  output logic                           out_last,
  output logic                           out_valid,
  input  logic                           out_ready
);

  localparam int CNT_W = $clog2(LANES + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(LANES);

  logic [DATAWIDTH*LANES-1:0] acc;
  logic [CNT_W-1:0]           acc_cnt;
  logic                       pending;
  logic                       flush_req;

  logic [CNT_W-1:0]           fill;
  logic                       out_free;
  logic                       svc_flush;
  logic                       load_full;
  logic                       emit;

  function automatic logic [LANES-1:0] lane_mask(input logic [CNT_W-1:0] cnt);
    logic [LANES-1:0] m;
    m = '0;
    for (int i = 0; i < LANES; i++)
      if (CNT_W'(i) < cnt) m[i] = 1'b1;
    return m;
  endfunction

  // Lanes already filled plus the one still in flight bound how far we may pop ahead.
  always_comb begin
    fill      = acc_cnt + {{(CNT_W-1){1'b0}}, pending};
    out_free  = !out_valid || out_ready;
    rd_en     = !fifo_empty && !flush_req && (fill < FULL) && !rd_rst;
    svc_flush = flush_req && !pending && out_free;
    load_full = (acc_cnt == FULL) && out_free && !svc_flush;
    emit      = load_full || (svc_flush && (acc_cnt != '0));
  end

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      acc       <= '0;
      acc_cnt   <= '0;
      pending   <= 1'b0;
      flush_req <= 1'b0;
      out_word  <= '0;
      out_keep  <= '0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      pending <= rd_en;

      if (emit) begin
        out_word  <= acc;
        out_keep  <= lane_mask(acc_cnt);
        out_last  <= svc_flush;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      // A full or flushed accumulator never has a byte in flight, so clear and write are exclusive.
      if (svc_flush || load_full) begin
        acc     <= '0;
        acc_cnt <= '0;
      end else if (pending) begin
        for (int i = 0; i < LANES; i++)
          if (acc_cnt == CNT_W'(i)) acc[i*DATAWIDTH +: DATAWIDTH] <= rd_data;
        acc_cnt <= acc_cnt + CNT_W'(1);
      end

      if (svc_flush)  flush_req <= 1'b0;
      else if (flush) flush_req <= 1'b1;
    end
  end

endmodule
